masked_serpar_buf: RTL and testbench

MASKED_SERPAR_BUF -- requirements
Module: masked_serpar_buf

---
 rtl/masked_serpar_buf.sv | 106 ++++++++++
 tb/tb_masked_serpar_buf.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_serpar_buf.sv
// Serial-to-parallel block buffer for a masked cipher core: loads NW words, hands the block to the core, then streams the result back out MSW first.
// Latency: last input word -> core_start 1 cycle; core_done -> first out_valid 1 cycle. Backpressure: in_ready only in LOAD, out_valid holds while out_ready=0.
// Build option SERPAR_CLR_ON_READ_EN: unload shifts in zeros (share erasure) instead of rotating the emitted word back in.
module masked_serpar_buf #(
   parameter int BLK_W = 128,
   parameter int NSEG  = 7,
   parameter int BUS_W = 8,
   localparam int TOT  = BLK_W * NSEG,
   localparam int NW   = TOT / BUS_W,
   localparam int CW   = $clog2(NW + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [BUS_W-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [TOT-1:0]   core_data,
   output logic             core_start,
   input  logic [TOT-1:0]   core_result,
   input  logic             core_done,
   output logic [BUS_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             flush,
   output logic [CW-1:0]    cnt
);

   typedef enum logic [1:0] {LOAD, FULL, BUSY, UNLOAD} state_t;

   localparam logic [CW-1:0] LAST = CW'(NW - 1);

   state_t           state_q, state_d;
   logic [TOT-1:0]   blk_q, blk_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BUS_W-1:0] fill;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD;
         blk_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef SERPAR_CLR_ON_READ_EN
   assign fill = '0;
`else
   assign fill = blk_q[TOT-1 -: BUS_W];
`endif

   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      cnt_d   = cnt_q;
      case (state_q)
         LOAD: begin
            if (in_valid) begin
               blk_d = {blk_q[TOT-BUS_W-1:0], in_data};
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = FULL;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         FULL: state_d = BUSY;
         BUSY: begin
            if (core_done) begin
               blk_d   = core_result;
               state_d = UNLOAD;
            end
         end
         UNLOAD: begin
            if (out_ready) begin
               blk_d = {blk_q[TOT-BUS_W-1:0], fill};
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = LOAD;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = LOAD;
      endcase
      // flush overrides every transfer, including the core handoff
      if (flush) begin
         state_d = LOAD;
         cnt_d   = '0;
         blk_d   = '0;
      end
   end

   assign in_ready   = rst_n && (state_q == LOAD);
   assign core_start = (state_q == FULL) && !flush;
   assign out_valid  = (state_q == UNLOAD);
   assign out_data   = blk_q[TOT-1 -: BUS_W];
   assign core_data  = blk_q;
   assign cnt        = cnt_q;

endmodule

// File: tb/tb_masked_serpar_buf.sv
// Randomized self-checking bench for masked_serpar_buf (default and 64x3/16-bit configurations).
module tb_masked_serpar_buf;

   localparam int BUSW = 8;
   localparam int TOT  = 128 * 7;
   localparam int NW   = TOT / BUSW;
   localparam int CW   = $clog2(NW + 1);
   localparam int SBUS = 16;
   localparam int STOT = 64 * 3;
   localparam int SNW  = STOT / SBUS;
   localparam int SCW  = $clog2(SNW + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [BUSW-1:0] in_data = '0, out_data;
   logic            in_valid = 1'b0, in_ready, core_start, core_done = 1'b0;
   logic            out_valid, out_ready = 1'b0, flush = 1'b0;
   logic [TOT-1:0]  core_data, core_result = '0;
   logic [CW-1:0]   cnt;

   logic [SBUS-1:0] s_in_data = '0, s_out_data;
   logic            s_in_valid = 1'b0, s_in_ready, s_core_start, s_core_done = 1'b0;
   logic            s_out_valid, s_out_ready = 1'b0, s_flush = 1'b0;
   logic [STOT-1:0] s_core_data, s_core_result = '0;
   logic [SCW-1:0]  s_cnt;

   int n_chk = 0;
   int n_fail = 0;

   logic [BUSW-1:0] ld [NW];
   logic [TOT-1:0]  exp_blk, res;

   masked_serpar_buf dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .core_data(core_data), .core_start(core_start), .core_result(core_result), .core_done(core_done),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .flush(flush), .cnt(cnt)
   );

   masked_serpar_buf #(.BLK_W(64), .NSEG(3), .BUS_W(16)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .core_data(s_core_data), .core_start(s_core_start), .core_result(s_core_result), .core_done(s_core_done),
      .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready), .flush(s_flush), .cnt(s_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [TOT-1:0] post_unload(input logic [TOT-1:0] r);
`ifdef SERPAR_CLR_ON_READ_EN
      return '0;
`else
      return r;
`endif
   endfunction

   // Drives all NW words of ld[] into the default DUT; returns positioned in the FULL cycle.
   task automatic load_words(input bit gaps);
      int acc = 0;
      int guard = 0;
      bit hs;
      for (int i = 0; i < NW; i++) exp_blk[TOT-1-i*BUSW -: BUSW] = ld[i];
      while (acc < NW && guard < 5000) begin
         n_chk++;
         if (in_ready !== 1'b1 || cnt !== CW'(acc)) begin
            n_fail++;
            $display("FAIL load_state word %0d: in_ready=%b cnt=%0d, required 1 and %0d", acc, in_ready, cnt, acc);
         end
         in_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data   = ld[acc];
         out_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
         hs = in_valid;
         @(posedge clk); #1; guard++;
         if (hs) acc++;
         n_chk++;
         if (core_start !== 1'(acc == NW)) begin
            n_fail++;
            $display("FAIL core_start_timing after %0d words: core_start=%b, required %b", acc, core_start, acc == NW);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      n_chk++;
      if (acc != NW) begin
         n_fail++;
         $display("FAIL load_timeout: accepted %0d words, required %0d", acc, NW);
      end
      n_chk++;
      if (cnt !== '0 || in_ready !== 1'b0 || core_data !== exp_blk) begin
         n_fail++;
         $display("FAIL full_state: cnt=%0d in_ready=%b core_data=%h, required 0 0 %h", cnt, in_ready, core_data, exp_blk);
      end
   endtask

   // From the FULL cycle: waits in BUSY, then returns res through core_done.
   task automatic finish_core(input int wait_cyc);
      @(posedge clk); #1;
      n_chk++;
      if (core_start !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_entry: core_start=%b out_valid=%b, required 0 0", core_start, out_valid);
      end
      repeat (wait_cyc) begin
         in_valid = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      in_valid    = 1'b0;
      core_result = res;
      core_done   = 1'b1;
      @(posedge clk); #1;
      core_done   = 1'b0;
      for (int i = 0; i < TOT / 32; i++) core_result[i*32 +: 32] = $urandom;
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== res[TOT-1 -: BUSW] || core_data !== res) begin
         n_fail++;
         $display("FAIL done_capture: out_valid=%b out_data=%h, required 1 %h", out_valid, out_data, res[TOT-1 -: BUSW]);
      end
   endtask

   // mode 0: always ready, 1: toggle 1/0, 2: random.
   task automatic unload_words(input int mode);
      int got = 0;
      int guard = 0;
      bit tog = 1'b1;
      bit hs;
      while (got < NW && guard < 5000) begin
         n_chk++;
         if (out_valid !== 1'b1 || out_data !== res[TOT-1-got*BUSW -: BUSW] || cnt !== CW'(got) || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL unload_word %0d: out_valid=%b out_data=%h cnt=%0d in_ready=%b, required 1 %h %0d 0",
                     got, out_valid, out_data, cnt, in_ready, res[TOT-1-got*BUSW -: BUSW], got);
         end
         out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
         tog       = ~tog;
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         hs = out_ready;
         @(posedge clk); #1; guard++;
         if (hs) got++;
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      n_chk++;
      if (got != NW) begin
         n_fail++;
         $display("FAIL unload_timeout: delivered %0d words, required %0d", got, NW);
      end
      n_chk++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || cnt !== '0 || core_data !== post_unload(res)) begin
         n_fail++;
         $display("FAIL unload_end: out_valid=%b in_ready=%b cnt=%0d core_data=%h, required 0 1 0 %h",
                  out_valid, in_ready, cnt, core_data, post_unload(res));
      end
   endtask

   task automatic test_reset;
      #2;
      n_chk++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || core_start !== 1'b0 || cnt !== '0 || core_data !== '0) begin
         n_fail++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b core_start=%b cnt=%0d, required all 0", in_ready, out_valid, core_start, cnt);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      n_chk++;
      if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: in_ready=%b s_in_ready=%b, required 1 1", in_ready, s_in_ready);
      end
      core_result = {TOT/8{8'h3C}};
      core_done   = 1'b1;
      @(posedge clk); #1;
      core_done   = 1'b0;
      n_chk++;
      if (core_data !== '0 || out_valid !== 1'b0 || cnt !== '0) begin
         n_fail++;
         $display("FAIL done_in_load: core_data=%h out_valid=%b, required 0 0", core_data, out_valid);
      end
   endtask

   task automatic test_load_fixed;
      for (int i = 0; i < NW; i++) ld[i] = 8'(i);
      load_words(1'b0);
      n_chk++;
      if (core_data[895:888] !== 8'h00 || core_data[7:0] !== 8'h6F) begin
         n_fail++;
         $display("FAIL fixed_ends: msb=%h lsb=%h, required 00 6f", core_data[895:888], core_data[7:0]);
      end
      res = {TOT/8{8'hA5}};
      finish_core(0);
      unload_words(0);
   endtask

   task automatic test_stall;
      for (int i = 0; i < NW; i++) ld[i] = 8'($urandom);
      load_words(1'b1);
      for (int i = 0; i < TOT / 32; i++) res[i*32 +: 32] = $urandom;
      finish_core(3);
      unload_words(1);
      for (int i = 0; i < NW; i++) ld[i] = 8'($urandom);
      load_words(1'b1);
      for (int i = 0; i < TOT / 32; i++) res[i*32 +: 32] = $urandom;
      finish_core(1);
      unload_words(2);
   endtask

   task automatic test_flush;
      for (int i = 0; i < NW; i++) ld[i] = 8'(i);
      for (int i = 0; i < 50; i++) begin
         in_valid = 1'b1;
         in_data  = ld[i];
         @(posedge clk); #1;
         n_chk++;
         if (core_start !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_preload_start word %0d: core_start=%b, required 0", i, core_start);
         end
      end
      flush   = 1'b1;
      in_data = ld[50];
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      n_chk++;
      if (cnt !== '0 || core_data !== '0 || in_ready !== 1'b1 || core_start !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_midload: cnt=%0d core_data=%h in_ready=%b core_start=%b, required 0 0 1 0",
                  cnt, core_data, in_ready, core_start);
      end
      load_words(1'b0);
      flush = 1'b1;
      #1;
      n_chk++;
      if (core_start !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_full_start: core_start=%b, required 0", core_start);
      end
      @(posedge clk); #1;
      flush = 1'b0;
      n_chk++;
      if (cnt !== '0 || core_data !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_full: cnt=%0d core_data=%h in_ready=%b out_valid=%b, required 0 0 1 0",
                  cnt, core_data, in_ready, out_valid);
      end
      load_words(1'b0);
      n_chk++;
      if (core_data[895:888] !== 8'h00 || core_data[7:0] !== 8'h6F) begin
         n_fail++;
         $display("FAIL flush_reload_ends: msb=%h lsb=%h, required 00 6f", core_data[895:888], core_data[7:0]);
      end
      for (int i = 0; i < TOT / 32; i++) res[i*32 +: 32] = $urandom;
      finish_core(0);
      unload_words(0);
   endtask

   task automatic test_reset_busy;
      for (int i = 0; i < NW; i++) ld[i] = 8'($urandom);
      load_words(1'b1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || core_data !== '0 || cnt !== '0 || core_start !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy_hold: in_ready=%b out_valid=%b core_data=%h cnt=%0d, required 0 0 0 0",
                  in_ready, out_valid, core_data, cnt);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      core_result = {TOT/8{8'h5A}};
      core_done   = 1'b1;
      #1;
      n_chk++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_busy_release: in_ready=%b, required 1", in_ready);
      end
      @(posedge clk); #1;
      core_done = 1'b0;
      n_chk++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || core_data !== '0 || cnt !== '0) begin
         n_fail++;
         $display("FAIL reset_busy_done: out_valid=%b in_ready=%b core_data=%h, required 0 1 0", out_valid, in_ready, core_data);
      end
   endtask

   task automatic test_small;
      logic [SBUS-1:0] s_ld [SNW];
      logic [STOT-1:0] s_exp;
      int acc = 0;
      int got = 0;
      int guard = 0;
      bit hs;
      for (int i = 0; i < SNW; i++) begin
         s_ld[i] = 16'($urandom);
         s_exp[STOT-1-i*SBUS -: SBUS] = s_ld[i];
      end
      while (acc < SNW && guard < 500) begin
         s_in_valid = 1'b1;
         s_in_data  = s_ld[acc];
         hs = s_in_ready;
         @(posedge clk); #1; guard++;
         if (hs) acc++;
         n_chk++;
         if (s_core_start !== 1'(acc == SNW)) begin
            n_fail++;
            $display("FAIL small_start after %0d words: core_start=%b, required %b", acc, s_core_start, acc == SNW);
         end
      end
      s_in_valid = 1'b0;
      n_chk++;
      if (s_core_data !== s_exp || s_cnt !== '0) begin
         n_fail++;
         $display("FAIL small_full: core_data=%h cnt=%0d, required %h 0", s_core_data, s_cnt, s_exp);
      end
      @(posedge clk); #1;
      s_core_result = s_exp;
      s_core_done   = 1'b1;
      @(posedge clk); #1;
      s_core_done   = 1'b0;
      s_core_result = '0;
      guard = 0;
      while (got < SNW && guard < 500) begin
         n_chk++;
         if (s_out_valid !== 1'b1 || s_out_data !== s_ld[got]) begin
            n_fail++;
            $display("FAIL small_read %0d: out_valid=%b out_data=%h, required 1 %h", got, s_out_valid, s_out_data, s_ld[got]);
         end
         s_out_ready = 1'b1;
         @(posedge clk); #1; guard++;
         got++;
      end
      s_out_ready = 1'b0;
      n_chk++;
`ifdef SERPAR_CLR_ON_READ_EN
      s_exp = '0;
`endif
      if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1 || s_cnt !== '0 || s_core_data !== s_exp) begin
         n_fail++;
         $display("FAIL small_end: out_valid=%b in_ready=%b cnt=%0d core_data=%h, required 0 1 0 %h",
                  s_out_valid, s_in_ready, s_cnt, s_core_data, s_exp);
      end
   endtask

   initial begin
      test_reset();
      test_load_fixed();
      test_stall();
      test_flush();
      test_reset_busy();
      test_small();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
